// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage: opcodes, ALUOp encodings and control bundle.
package id_ex_stage_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam int unsigned CNT_W = 32;

  // Control signals travelling from decode into EX, 8 bits total.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detection between the decode slot and the load sitting in EX.
module hazard_unit
  import id_ex_stage_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       flush,
  output logic       hazard_c,
  output logic       stall_c
);

  assign hazard_c = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // A taken branch squashes the dependent instruction, so there is nothing to wait for.
  assign stall_c = hazard_c & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and flush squashing.
// Define ID_EX_PERF_EN to add saturating bubble_cnt/stall_cnt performance counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_5,
  input  logic            id_RegWrite,
  input  logic            id_MemtoReg,
  input  logic            id_MemRead,
  input  logic            id_MemWrite,
  input  logic            id_Branch,
  input  logic            id_ALUSrc,
  input  logic [1:0]      id_ALUOp,
  input  logic            flush,
  output logic            stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7_5,
  output logic            ex_RegWrite,
  output logic            ex_MemtoReg,
  output logic            ex_MemRead,
  output logic            ex_MemWrite,
  output logic            ex_Branch,
  output logic            ex_ALUSrc,
  output logic [1:0]      ex_ALUOp
`ifdef ID_EX_PERF_EN
  ,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  hazard;
  logic  bubble;

  assign id_ctrl = '{reg_write:  id_RegWrite,
                     mem_to_reg: id_MemtoReg,
                     mem_read:   id_MemRead,
                     mem_write:  id_MemWrite,
                     branch:     id_Branch,
                     alu_src:    id_ALUSrc,
                     alu_op:     id_ALUOp};

  hazard_unit u_hazard (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .flush       (flush),
    .hazard_c    (hazard),
    .stall_c     (stall)
  );

  assign bubble = flush | hazard;

  // Bubbles clear only valid and control; operand fields keep their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7_5 <= 1'b0;
    end else if (bubble) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else begin
      ex_valid    <= id_valid;
      ex_ctrl     <= id_valid ? id_ctrl : '0;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct3   <= id_funct3;
      ex_funct7_5 <= id_funct7_5;
    end
  end

  assign ex_RegWrite = ex_ctrl.reg_write;
  assign ex_MemtoReg = ex_ctrl.mem_to_reg;
  assign ex_MemRead  = ex_ctrl.mem_read;
  assign ex_MemWrite = ex_ctrl.mem_write;
  assign ex_Branch   = ex_ctrl.branch;
  assign ex_ALUSrc   = ex_ctrl.alu_src;
  assign ex_ALUOp    = ex_ctrl.alu_op;

`ifdef ID_EX_PERF_EN
  // Saturating event counters; reset takes priority over any event that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (bubble && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (stall && (stall_cnt != '1))   stall_cnt  <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver queues expectations, negedge monitor checks them.
module tb_id_ex_stage;

  localparam int unsigned XLEN = 64;
  localparam int K_LOAD   = 0;
  localparam int K_BUBBLE = 1;
  localparam int K_RST    = 2;

  localparam logic [7:0] C_RTYPE = 8'b1000_0010;
  localparam logic [7:0] C_LOAD  = 8'b1110_0100;
  localparam logic [7:0] C_STORE = 8'b0001_0100;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1d;
    logic [XLEN-1:0] rs2d;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      f3;
    logic            f75;
    logic [7:0]      ctrl;
  } ex_t;

  typedef struct packed {
    int   id;
    logic stall;
    ex_t  ex;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  ex_t  idv = '0;
  ex_t  ex_now;
  logic stall;

  logic            ex_valid, ex_funct7_5;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [2:0]      ex_funct3;
  logic            ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_Branch, ex_ALUSrc;
  logic [1:0]      ex_ALUOp;
`ifdef ID_EX_PERF_EN
  logic [31:0]     bubble_cnt, stall_cnt;
`endif

  exp_t q[$];
  ex_t  last_exp = '0;
  int   checks = 0;
  int   passes = 0;
  int   step_no = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .id_valid(idv.valid), .id_pc(idv.pc),
    .id_rs1_data(idv.rs1d), .id_rs2_data(idv.rs2d), .id_imm(idv.imm),
    .id_rs1(idv.rs1), .id_rs2(idv.rs2), .id_rd(idv.rd),
    .id_funct3(idv.f3), .id_funct7_5(idv.f75),
    .id_RegWrite(idv.ctrl[7]), .id_MemtoReg(idv.ctrl[6]), .id_MemRead(idv.ctrl[5]),
    .id_MemWrite(idv.ctrl[4]), .id_Branch(idv.ctrl[3]), .id_ALUSrc(idv.ctrl[2]),
    .id_ALUOp(idv.ctrl[1:0]), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7_5(ex_funct7_5),
    .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch), .ex_ALUSrc(ex_ALUSrc),
    .ex_ALUOp(ex_ALUOp)
`ifdef ID_EX_PERF_EN
    , .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
`endif
  );

  assign ex_now = '{valid: ex_valid, pc: ex_pc, rs1d: ex_rs1_data, rs2d: ex_rs2_data,
                    imm: ex_imm, rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd, f3: ex_funct3,
                    f75: ex_funct7_5,
                    ctrl: {ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite,
                           ex_Branch, ex_ALUSrc, ex_ALUOp}};

  function automatic ex_t mk(input logic [XLEN-1:0] pc, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                             input logic [XLEN-1:0] imm, input logic [7:0] ctrl,
                             input logic v);
    ex_t r;
    r = '{valid: v, pc: pc, rs1d: d1, rs2d: d2, imm: imm, rs1: rs1, rs2: rs2, rd: rd,
          f3: pc[4:2], f75: pc[3], ctrl: ctrl};
    return r;
  endfunction

  // Apply one cycle of inputs; the expectation covers stall now and ex_* after the next edge.
  task automatic step(input logic r, input logic f, input ex_t v, input logic es,
                      input int kind, input bit push);
    ex_t e;
    @(posedge clk);
    #1;
    rst = r;
    flush = f;
    idv = v;
    step_no++;
    case (kind)
      K_LOAD:   begin e = v; if (!v.valid) e.ctrl = 8'h00; end
      K_BUBBLE: begin e = last_exp; e.valid = 1'b0; e.ctrl = 8'h00; end
      default:  e = '0;
    endcase
    last_exp = e;
    if (push) q.push_back('{id: step_no, stall: es, ex: e});
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endtask

  // Monitor: check stall against the current entry, ex_* one cycle later.
  initial begin
    exp_t cur;
    ex_t  pend;
    int   pend_id;
    bit   have = 1'b0;
    forever begin
      @(negedge clk);
      if (have) begin
        checks++;
        if (ex_now === pend) passes++;
        else $display("FAIL ex_regs step%0d: actual %h required %h", pend_id, ex_now, pend);
      end
      if (q.size() > 0) begin
        cur = q.pop_front();
        checks++;
        if (stall === cur.stall) passes++;
        else $display("FAIL stall step%0d: actual %b required %b", cur.id, stall, cur.stall);
        pend = cur.ex;
        pend_id = cur.id;
        have = 1'b1;
      end else begin
        have = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ex_t rv, rt, ld7, dep7, ldx0, use0, ld10, ld11, dep11, inv, ld8, inv8, ld6, dep6, fl, rt2;
    rv    = mk(64'hDEAD_BEEF, 5'd1, 5'd2, 5'd3, 64'h11, 64'h22, 64'h33, C_LOAD, 1'b1);
    rt    = mk(64'h100, 5'd1, 5'd2, 5'd5, 64'h10, 64'h20, 64'h0, C_RTYPE, 1'b1);
    ld7   = mk(64'h104, 5'd3, 5'd0, 5'd7, 64'h1000, 64'h0, 64'h8, C_LOAD, 1'b1);
    dep7  = mk(64'h108, 5'd4, 5'd7, 5'd9, 64'h44, 64'h77, 64'h0, C_RTYPE, 1'b1);
    ldx0  = mk(64'h10C, 5'd5, 5'd0, 5'd0, 64'h2000, 64'h0, 64'h4, C_LOAD, 1'b1);
    use0  = mk(64'h110, 5'd0, 5'd0, 5'd3, 64'h0, 64'h0, 64'h0, C_RTYPE, 1'b1);
    ld10  = mk(64'h114, 5'd1, 5'd0, 5'd10, 64'h3000, 64'h0, 64'h10, C_LOAD, 1'b1);
    ld11  = mk(64'h118, 5'd2, 5'd0, 5'd11, 64'h3100, 64'h0, 64'h18, C_LOAD, 1'b1);
    dep11 = mk(64'h11C, 5'd11, 5'd10, 5'd12, 64'hAA, 64'hBB, 64'h0, C_RTYPE, 1'b1);
    inv   = mk(64'h200, 5'd13, 5'd14, 5'd15, 64'h5, 64'h6, 64'h7, C_STORE, 1'b0);
    ld8   = mk(64'h204, 5'd1, 5'd0, 5'd8, 64'h4000, 64'h0, 64'h20, C_LOAD, 1'b1);
    inv8  = mk(64'h208, 5'd8, 5'd8, 5'd1, 64'h9, 64'h9, 64'h0, C_RTYPE, 1'b0);
    ld6   = mk(64'h20C, 5'd2, 5'd0, 5'd6, 64'h5000, 64'h0, 64'h28, C_LOAD, 1'b1);
    dep6  = mk(64'h210, 5'd6, 5'd1, 5'd2, 64'h66, 64'h11, 64'h0, C_RTYPE, 1'b1);
    fl    = mk(64'h214, 5'd3, 5'd4, 5'd5, 64'hF1, 64'hF2, 64'h0, C_RTYPE, 1'b1);
    rt2   = mk(64'h300, 5'd6, 5'd7, 5'd8, 64'hC1, 64'hC2, 64'h0, C_RTYPE, 1'b1);

    idv = rv;
    step(1'b1, 1'b0, rv, 1'b0, K_RST, 1'b0);      // first reset edge, regs not yet defined
    step(1'b1, 1'b0, rv, 1'b0, K_RST, 1'b1);      // second reset cycle: all zero
    step(1'b0, 1'b0, rt, 1'b0, K_LOAD, 1'b1);     // pass-through R-type
    step(1'b0, 1'b0, ld7, 1'b0, K_LOAD, 1'b1);
    step(1'b0, 1'b0, dep7, 1'b1, K_BUBBLE, 1'b1); // load-use stall
    step(1'b0, 1'b0, dep7, 1'b0, K_LOAD, 1'b1);   // one cycle only
    step(1'b0, 1'b0, ldx0, 1'b0, K_LOAD, 1'b1);
    step(1'b0, 1'b0, use0, 1'b0, K_LOAD, 1'b1);   // x0 never stalls
    step(1'b0, 1'b0, ld10, 1'b0, K_LOAD, 1'b1);
    step(1'b0, 1'b0, ld11, 1'b0, K_LOAD, 1'b1);
    step(1'b0, 1'b0, dep11, 1'b1, K_BUBBLE, 1'b1);
    step(1'b0, 1'b0, dep11, 1'b0, K_LOAD, 1'b1);
    step(1'b0, 1'b0, ld7, 1'b0, K_LOAD, 1'b1);
    step(1'b0, 1'b1, dep7, 1'b0, K_BUBBLE, 1'b1); // flush beats hazard
    step(1'b0, 1'b0, inv, 1'b0, K_LOAD, 1'b1);    // invalid slot zeroes control
`ifdef ID_EX_PERF_EN
    chk32("bubble_cnt_after_flush", bubble_cnt, 32'd3);
    chk32("stall_cnt_after_flush", stall_cnt, 32'd2);
`endif
    step(1'b0, 1'b0, ld8, 1'b0, K_LOAD, 1'b1);
    step(1'b0, 1'b0, inv8, 1'b0, K_LOAD, 1'b1);   // invalid slot cannot stall
    step(1'b0, 1'b0, ld6, 1'b0, K_LOAD, 1'b1);
    step(1'b1, 1'b0, dep6, 1'b1, K_RST, 1'b1);    // reset during stall
    step(1'b0, 1'b0, dep6, 1'b0, K_LOAD, 1'b1);   // normal load right after reset
`ifdef ID_EX_PERF_EN
    chk32("bubble_cnt_after_rst", bubble_cnt, 32'd0);
    chk32("stall_cnt_after_rst", stall_cnt, 32'd0);
`endif
    step(1'b0, 1'b1, fl, 1'b0, K_BUBBLE, 1'b1);   // plain flush, data held
`ifdef ID_EX_PERF_EN
    force dut.bubble_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.bubble_cnt;
`endif
    step(1'b0, 1'b0, rt2, 1'b0, K_LOAD, 1'b1);
`ifdef ID_EX_PERF_EN
    chk32("bubble_cnt_saturate", bubble_cnt, 32'hFFFF_FFFF);
    chk32("stall_cnt_final", stall_cnt, 32'd0);
`endif

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL queue_drain: actual %0d entries required 0", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath width of operands, immediate and PC.
REQ-002 Ports clk and rst: clk input 1, sole clock, rising edge; rst input 1, synchronous, active-high reset.
REQ-003 id_valid input 1, decode slot holds a real instruction.
REQ-004 id_pc input XLEN; id_rs1_data, id_rs2_data input XLEN, register file reads; id_imm input XLEN, sign-extended immediate.
REQ-005 id_rs1, id_rs2, id_rd input 5, register indices; id_funct3 input 3; id_funct7_5 input 1, instruction bit 30.
REQ-006 id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_Branch, id_ALUSrc input 1 each; id_ALUOp input 2, all from control_unit.
REQ-007 flush input 1, branch resolved taken; squash the decode-slot instruction.
REQ-008 stall output 1, combinational, freezes PC and IF/ID register.
REQ-009 ex_valid output 1; ex_pc, ex_rs1_data, ex_rs2_data, ex_imm output XLEN; ex_rs1, ex_rs2, ex_rd output 5; ex_funct3 output 3; ex_funct7_5 output 1.
REQ-010 ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_Branch, ex_ALUSrc output 1 each; ex_ALUOp output 2, registered control to EX.

Function
REQ-011 The block SHALL compute hazard = ex_valid & ex_MemRead & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
REQ-012 stall SHALL equal hazard & ~flush; flush always wins.
REQ-013 Each rising edge, priority order: rst, then flush, then hazard, then normal load.
REQ-014 Flush or hazard SHALL load a bubble: ex_valid=0 and all seven control outputs=0; data/index fields SHALL hold their previous values.
REQ-015 Normal load SHALL capture every id_* field into its ex_* twin, with ex_valid=id_valid; when id_valid=0 all control outputs SHALL load 0.
REQ-016 Latency: one cycle from id_* to ex_*; no combinational path from id_* to ex_*.
REQ-017 A load-use stall SHALL last exactly one cycle: the inserted bubble clears ex_valid, so hazard deasserts the next cycle.
REQ-018 Back-to-back loads with a dependent third instruction SHALL each stall one cycle only where REQ-011 holds.
REQ-019 rd=x0 SHALL never cause a stall.
REQ-020 Flush and hazard in the same cycle: bubble inserted, stall=0.

Reset
REQ-021 On rst the block SHALL clear ex_valid, all control outputs and every data/index output to 0; stall SHALL be 0 while ex_valid=0.
REQ-022 rst asserted mid-stall SHALL override; the first post-reset cycle SHALL behave as normal load.

Configuration
REQ-023 Macro ID_EX_PERF_EN SHALL, when defined, add outputs bubble_cnt and stall_cnt, 32 bits each, reset to 0.
REQ-024 With ID_EX_PERF_EN, bubble_cnt SHALL increment on each flush-or-hazard bubble and stall_cnt on each stall cycle, both saturating at 0xFFFFFFFF.
REQ-025 Without ID_EX_PERF_EN these ports and counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-026 A shared package SHALL hold the opcode constants (R-type 0110011, load 0000011, store 0100011, branch 1100011), the ALUOp encodings, and a packed control-bundle typedef (7 fields, 8 bits).
REQ-027 Hazard detection SHALL be a sub-module hazard_unit, purely combinational, instantiated once; the register SHALL live in id_ex_stage.

Verification
REQ-028 Reset: rst=1 for two cycles with id inputs nonzero -> all ex_* = 0, stall=0.
REQ-029 Pass-through: R-type, id_rd=5, id_rs1_data=0x10, id_ALUOp=2'b10, RegWrite=1 -> next cycle ex_rd=5, ex_rs1_data=0x10, ex_ALUOp=2'b10, ex_RegWrite=1, ex_valid=1.
REQ-030 Load-use: load to x7, then id_rs2=7 -> stall=1 one cycle, bubble (ex_valid=0), dependent instruction enters EX the following cycle with stall=0.
REQ-031 x0 load: load ex_rd=0, then id_rs1=0 -> stall=0, no bubble.
REQ-032 Flush plus hazard: condition of REQ-030 with flush=1 -> stall=0, bubble loaded, perf counts bubble_cnt=1, stall_cnt=0.
REQ-033 Counter saturation (ID_EX_PERF_EN): preload bubble_cnt to 0xFFFFFFFF by force, then one flush -> bubble_cnt stays 0xFFFFFFFF.
